key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: cycles the synchronized input must stay stable to be accepted; legal range >= 2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000: cycles held after the accepted press before auto-repeat starts; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000: period of auto-repeat pulses; legal range >= 2.
REQ-004 clk_i  input  1  system clock, all logic on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 btn_i  input  1  raw asynchronous button level, active-high, may bounce.
REQ-007 repeat_en_i  input  1  enables auto-repeat pulses while the button is held; synchronous to clk_i.
REQ-008 btn_state_o  output  1  debounced button level.
REQ-009 btn_was_pressed_o  output  1  one-cycle pulse per accepted press and per auto-repeat event; feeds the load enable of the downstream data register.
REQ-010 btn_was_released_o  output  1  one-cycle pulse per accepted release.

Function
REQ-011 btn_i SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second flop output (sync).
REQ-012 SHALL implement the FSM states IDLE, PRESS_WAIT, PRESSED, REPEAT and RELEASE_WAIT, with one shared counter cnt.
REQ-013 cnt width SHALL be ceil(log2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1)); cnt SHALL never wrap.
REQ-014 IDLE: when sync=1, go to PRESS_WAIT with cnt=0; otherwise stay.
REQ-015 PRESS_WAIT: sync=0 returns to IDLE with cnt=0 (glitch rejected, no pulse).
REQ-016 PRESS_WAIT: if sync=1 and cnt=DEBOUNCE_CYCLES-1, go to PRESSED, clear cnt, and pulse btn_was_pressed_o for one cycle; otherwise increment cnt.
REQ-017 PRESSED: sync=0 goes to RELEASE_WAIT with cnt=0; this takes priority over the hold timeout.
REQ-018 PRESSED: if repeat_en_i=1 and cnt=HOLD_CYCLES-1, go to REPEAT, clear cnt and pulse; if repeat_en_i=0, cnt saturates at HOLD_CYCLES-1 with no pulse.
REQ-019 REPEAT: sync=0 goes to RELEASE_WAIT with cnt=0.
REQ-020 REPEAT: if cnt=REPEAT_CYCLES-1, pulse and clear cnt.
REQ-021 REPEAT: if repeat_en_i drops, return to PRESSED with cnt saturated, so no further pulses occur.
REQ-022 RELEASE_WAIT: sync=1 returns to PRESSED with cnt=0; the bounce is ignored and no pulse is produced.
REQ-023 RELEASE_WAIT: if sync=0 and cnt=DEBOUNCE_CYCLES-1, go to IDLE and pulse btn_was_released_o.
REQ-024 btn_state_o SHALL be 1 exactly in PRESSED, REPEAT and RELEASE_WAIT.
REQ-025 All outputs SHALL be registered; btn_was_pressed_o and btn_was_released_o SHALL never be high in the same cycle or for two consecutive cycles.
REQ-026 Latency: with btn_i first sampled high at edge k and stable thereafter, btn_was_pressed_o SHALL be high exactly between edges k+DEBOUNCE_CYCLES+2 and k+DEBOUNCE_CYCLES+3.
REQ-027 Release latency SHALL be symmetric to press latency.

Reset
REQ-028 On rstn_i low: state=IDLE, cnt=0, synchronizer flops=0, and all outputs=0, immediately and independent of clk_i.
REQ-029 Reset asserted mid-press (any state) SHALL produce no release pulse.
REQ-030 After reset deassertion with btn_i held high, the button SHALL be treated as a new press: a full debounce, then a pulse.

Structure
REQ-031 State encodings SHALL be shared localparam constants in a common definitions file, key_debouncer_defs, reused by the bench for state checks.
REQ-032 The synchronizer SHALL be a separate sub-module, sync_2ff, parameterised by width and reset value 0.
REQ-033 The counter and FSM SHALL reside in key_debouncer; there SHALL be no other sub-modules.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
REQ-034 Clean press sampled at edge 0, held 20 cycles, repeat_en_i=0 -> btn_was_pressed_o high only between edges 6 and 7; btn_state_o=1 from edge 6.
REQ-035 Bounce 1,0,1,0 on consecutive cycles, then 0 -> no pulse, btn_state_o stays 0, FSM returns to IDLE.
REQ-036 Held press with repeat_en_i=1 -> press pulse after edge 6, then pulses after edges 14, 17 and 20 while held; release sampled at edge 21 -> release pulse after edge 27, no further press pulses.
REQ-037 1-cycle high glitch during RELEASE_WAIT -> no release pulse; release pulse only after 4 further stable low cycles plus synchronizer delay.
REQ-038 rstn_i asserted while in REPEAT -> all outputs 0 immediately; deassert with btn_i high -> press pulse 6 edges after the first sampling edge, no release pulse at any time.

Source files
------------

// File: rtl/key_debouncer_defs.sv
// key_debouncer_defs: shared state encodings and sizing helper for the key debouncer
package key_debouncer_defs;
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] ST_PRESSED      = 3'd2;
  localparam logic [2:0] ST_REPEAT       = 3'd3;
  localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;
  typedef enum logic [2:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    REPEAT       = ST_REPEAT,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } state_e;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  // first flop may go metastable; second flop gives it a cycle to resolve
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: debounces a raw button and emits press, release and auto-repeat pulses
module key_debouncer
  import key_debouncer_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic btn_state_o,
  output logic btn_was_pressed_o,
  output logic btn_was_released_o
);
  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic          sync;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_state_q, btn_state_d;
  logic          pressed_q, pressed_d;
  logic          released_q, released_d;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .d_i   (btn_i),
    .q_o   (sync)
  );

  // next-state, shared counter and pulse decode; release always wins over timers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          pressed_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          if (repeat_en_i) begin
            state_d   = REPEAT;
            cnt_d     = '0;
            pressed_d = 1'b1;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      REPEAT: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (!repeat_en_i) begin
          state_d = PRESSED;
          cnt_d   = HOLD_LAST;
        end else if (cnt_q == REP_LAST) begin
          cnt_d     = '0;
          pressed_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          released_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    btn_state_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
  end

  // state, counter and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_state_q <= 1'b0;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_state_q <= btn_state_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
    end
  end

  assign btn_state_o        = btn_state_q;
  assign btn_was_pressed_o  = pressed_q;
  assign btn_was_released_o = released_q;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench for press/release/repeat pulse timing
module tb_key_debouncer;
  import key_debouncer_defs::*;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic btn_i = 1'b0;
  logic repeat_en_i = 1'b0;
  logic btn_state_o, btn_was_pressed_o, btn_was_released_o;
  int cyc = 0;
  int vec = 0;
  int miss = 0;
  typedef struct { int cyc; bit rel; } ev_t;
  ev_t sb[$];

  key_debouncer #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .btn_i             (btn_i),
    .repeat_en_i       (repeat_en_i),
    .btn_state_o       (btn_state_o),
    .btn_was_pressed_o (btn_was_pressed_o),
    .btn_was_released_o(btn_was_released_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (btn_was_pressed_o && btn_was_released_o) begin
      vec++;
      miss++;
      $display("FAIL both_pulses cyc=%0d press and release high together", cyc);
    end
    if (btn_was_pressed_o || btn_was_released_o) begin
      vec++;
      if (sb.size() == 0) begin
        miss++;
        $display("FAIL unexpected_pulse cyc=%0d rel=%0b, none expected", cyc, btn_was_released_o);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.cyc !== cyc || e.rel !== btn_was_released_o) begin
          miss++;
          $display("FAIL pulse got cyc=%0d rel=%0b, expected cyc=%0d rel=%0b", cyc, btn_was_released_o, e.cyc, e.rel);
        end
      end
    end
  end

  task automatic check_drained(input string name);
    vec++;
    if (sb.size() != 0) begin
      miss++;
      $display("FAIL %s_pending got %0d pulses outstanding, expected 0 (next cyc=%0d)", name, sb.size(), sb[0].cyc);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    vec++;
    if ({btn_state_o, btn_was_pressed_o, btn_was_released_o} !== 3'b000) begin
      miss++;
      $display("FAIL reset_outputs got %b expected 000", {btn_state_o, btn_was_pressed_o, btn_was_released_o});
    end
    vec++;
    if (dut.state_q !== ST_IDLE) begin
      miss++;
      $display("FAIL reset_state got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_clean_press();
    int k, k2;
    k = cyc + 1;
    btn_i = 1'b1;
    sb.push_back('{k + 6, 1'b0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (cyc == k + 5) begin
        vec++;
        if (btn_state_o !== 1'b0) begin miss++; $display("FAIL press_state_early got %b expected 0", btn_state_o); end
      end
      if (cyc == k + 6) begin
        vec++;
        if (btn_state_o !== 1'b1) begin miss++; $display("FAIL press_state got %b expected 1", btn_state_o); end
      end
    end
    btn_i = 1'b0;
    k2 = cyc + 1;
    sb.push_back('{k2 + 6, 1'b1});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (cyc == k2 + 5) begin
        vec++;
        if (btn_state_o !== 1'b1) begin miss++; $display("FAIL release_state_early got %b expected 1", btn_state_o); end
      end
      if (cyc == k2 + 6) begin
        vec++;
        if (btn_state_o !== 1'b0) begin miss++; $display("FAIL release_state got %b expected 0", btn_state_o); end
      end
    end
    check_drained("clean_press");
  endtask

  task automatic test_bounce();
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      btn_i = pat[i];
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      vec++;
      if (btn_state_o !== 1'b0) begin miss++; $display("FAIL bounce_state cyc=%0d got %b expected 0", cyc, btn_state_o); end
    end
    vec++;
    if (dut.state_q !== ST_IDLE) begin
      miss++;
      $display("FAIL bounce_fsm got %0d expected %0d", dut.state_q, ST_IDLE);
    end
    check_drained("bounce");
  endtask

  task automatic test_repeat();
    int k;
    @(negedge clk_i);
    repeat_en_i = 1'b1;
    k = cyc + 1;
    btn_i = 1'b1;
    sb.push_back('{k + 6, 1'b0});
    sb.push_back('{k + 14, 1'b0});
    sb.push_back('{k + 17, 1'b0});
    sb.push_back('{k + 20, 1'b0});
    sb.push_back('{k + 27, 1'b1});
    while (cyc < k + 20) @(negedge clk_i);
    btn_i = 1'b0;
    while (cyc < k + 35) @(negedge clk_i);
    repeat_en_i = 1'b0;
    check_drained("repeat");
  endtask

  task automatic test_release_glitch();
    int k, k2;
    @(negedge clk_i);
    k = cyc + 1;
    btn_i = 1'b1;
    sb.push_back('{k + 6, 1'b0});
    repeat (10) @(negedge clk_i);
    btn_i = 1'b0;
    k2 = cyc + 1;
    sb.push_back('{k2 + 9, 1'b1});
    repeat (2) @(negedge clk_i);
    btn_i = 1'b1;
    @(negedge clk_i);
    btn_i = 1'b0;
    while (cyc < k2 + 15) begin
      @(negedge clk_i);
      if (cyc == k2 + 3) begin
        vec++;
        if (dut.state_q !== ST_RELEASE_WAIT) begin miss++; $display("FAIL glitch_rw got %0d expected %0d", dut.state_q, ST_RELEASE_WAIT); end
      end
      if (cyc == k2 + 4) begin
        vec++;
        if (dut.state_q !== ST_PRESSED) begin miss++; $display("FAIL glitch_back got %0d expected %0d", dut.state_q, ST_PRESSED); end
      end
      if (cyc == k2 + 8) begin
        vec++;
        if (btn_state_o !== 1'b1) begin miss++; $display("FAIL glitch_state_held got %b expected 1", btn_state_o); end
      end
      if (cyc == k2 + 9) begin
        vec++;
        if (btn_state_o !== 1'b0) begin miss++; $display("FAIL glitch_state_rel got %b expected 0", btn_state_o); end
      end
    end
    check_drained("release_glitch");
  endtask

  task automatic test_reset_in_repeat();
    int k, e;
    @(negedge clk_i);
    repeat_en_i = 1'b1;
    k = cyc + 1;
    btn_i = 1'b1;
    sb.push_back('{k + 6, 1'b0});
    sb.push_back('{k + 14, 1'b0});
    while (cyc < k + 15) @(negedge clk_i);
    vec++;
    if (dut.state_q !== ST_REPEAT) begin miss++; $display("FAIL rst_pre_state got %0d expected %0d", dut.state_q, ST_REPEAT); end
    rstn_i = 1'b0;
    repeat_en_i = 1'b0;
    #1;
    vec++;
    if ({btn_state_o, btn_was_pressed_o, btn_was_released_o} !== 3'b000) begin
      miss++;
      $display("FAIL rst_async_outputs got %b expected 000", {btn_state_o, btn_was_pressed_o, btn_was_released_o});
    end
    vec++;
    if (dut.state_q !== ST_IDLE) begin miss++; $display("FAIL rst_async_state got %0d expected %0d", dut.state_q, ST_IDLE); end
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    e = cyc;
    sb.push_back('{e + 7, 1'b0});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (cyc == e + 6) begin
        vec++;
        if (btn_state_o !== 1'b0) begin miss++; $display("FAIL rst_repress_early got %b expected 0", btn_state_o); end
      end
      if (cyc == e + 7) begin
        vec++;
        if (btn_state_o !== 1'b1) begin miss++; $display("FAIL rst_repress_state got %b expected 1", btn_state_o); end
      end
    end
    btn_i = 1'b0;
    sb.push_back('{cyc + 7, 1'b1});
    repeat (12) @(negedge clk_i);
    check_drained("reset_in_repeat");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_release_glitch();
    test_reset_in_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
